multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequencer for the shared multi-cycle multiply/divide unit in the execute stage.
- Takes the decoded isMult/isDiv flags and the bypassed operands from the decode/execute stage, then issues one start pulse to the unit.
- Holds the front of the pipeline stalled until the unit responds, then emits one writeback beat into the MW path.
- Handles flush (jump/branch kill), unit timeout and exception mapping to $rstatus (r30).

Parameters:
- TIMEOUT, 40: max cycles from start pulse to unit_ready before the op is declared failed.
- CNT_W, 6: width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- is_mult  in  1  decode flag: current DX instruction is mul.
- is_div  in  1  decode flag: current DX instruction is div.
- op_a  in  32  bypassed rs operand.
- op_b  in  32  bypassed rt operand.
- rd  in  5  destination register (instruction[26:22]).
- flush  in  1  kill in-flight and requesting op (taken jump/branch).
- unit_ready  in  1  unit result valid, one-cycle pulse.
- unit_result  in  32  unit product/quotient.
- unit_exc  in  1  unit overflow / divide-by-zero, valid with unit_ready.
- ctrl_mult  out  1  one-cycle start pulse, multiply.
- ctrl_div  out  1  one-cycle start pulse, divide.
- unit_a  out  32  latched operand A, held stable from start to ready.
- unit_b  out  32  latched operand B, held stable from start to ready.
- stall  out  1  freeze PC, FD and DX latches.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_reg  out  5  writeback register.
- wb_data  out  32  writeback data.
- busy  out  1  state != IDLE.
- perf_ops  out  16  completed-op count (see Optional Feature).
- perf_stall  out  16  stall-cycle count (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE. All outputs and internal registers go to 0.
- req = (is_mult | is_div) & ~flush. If is_mult and is_div are both high, the op is treated as multiply.
- IDLE:
  - On req, latch op_a/op_b/rd and the op kind, clear the counter, and go to START.
  - Stall is asserted combinationally in the request cycle.
- START (1 cycle):
  - ctrl_mult or ctrl_div = 1 from a register; unit_a/unit_b are already valid.
  - Go to WAIT; counter=1.
- WAIT:
  - Counter increments each cycle.
  - If unit_ready: capture result/exc and go to WB.
  - Else if counter==TIMEOUT: force exc=1 and go to WB.
- WB (1 cycle):
  - wb_valid=1. If no exc: wb_reg=latched rd, wb_data=unit_result.
  - If exc: wb_reg=30, wb_data=4 (mul) or 5 (div).
  - Writes with rd==0 still pulse wb_valid; the regfile drops them.
  - Go to IDLE; stall deasserts the cycle after WB.
- stall = (state==IDLE & req) | START | WAIT | WB.
- flush in START or WAIT: go to DRAIN with no writeback. stall drops the next cycle; busy stays 1.
- DRAIN:
  - Ignores the result and waits for unit_ready or counter==TIMEOUT, then goes to IDLE.
  - A new req during DRAIN is held stalled (stall=1) until IDLE.
- flush in WB: the writeback still completes (the op is older than the flushing jump).
- unit_ready outside WAIT/DRAIN is ignored.
- Latency with unit_ready k cycles after the start pulse: wb_valid is exactly k+1 cycles after ctrl_* (k≥1).
- Reset mid-operation returns to IDLE the next edge with no pulse or writeback.

Optional Feature:
- Macro MULTDIV_PERF_EN.
- When defined:
  - perf_ops increments on each wb_valid without exc.
  - perf_stall increments every cycle stall==1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: both outputs are constant 0 and no counter logic is synthesised.

Test Plan:
- Mul, op_a=7, op_b=6, rd=5, unit_ready 3 cycles after pulse with result 42 -> ctrl_mult 1 pulse; wb_valid 4 cycles after pulse, wb_reg=5, wb_data=42; stall high req..WB inclusive.
- Div, op_a=9, op_b=0, unit_ready+unit_exc -> wb_reg=30, wb_data=5; ctrl_div single pulse, ctrl_mult never high.
- Mul, unit never ready, TIMEOUT=40 -> WB on counter 40, wb_reg=30, wb_data=4, then IDLE, busy=0.
- Flush 2 cycles into WAIT, unit_ready 5 cycles later -> no wb_valid; busy stays 1 until ready; a new mul issued during DRAIN starts only after IDLE.
- is_mult=is_div=1 with flush=1 -> no start; both asserted without flush -> ctrl_mult only.
- reset low in WAIT -> next cycle all outputs 0; a late unit_ready is ignored. With MULTDIV_PERF_EN, after scenario 1 -> perf_ops=1, perf_stall=6.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide unit in the execute stage.
// Latches the operands, issues a single start pulse, stalls the front of the pipeline
// until the unit answers (or times out), then emits one writeback beat. Exceptions and
// timeouts are redirected to $rstatus (r30) with code 4 (mul) or 5 (div).
// Optional feature macro: MULTDIV_PERF_EN enables the perf_ops/perf_stall counters.
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd,
    input  logic        flush,
    input  logic        unit_ready,
    input  logic [31:0] unit_result,
    input  logic        unit_exc,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_stall
);

    localparam logic [4:0] RstatusReg = 5'd30;

    typedef enum logic [2:0] {StIdle, StStart, StWait, StWb, StDrain} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_req;
    logic             w_accept;
    logic             w_timeout;
    logic             w_to_wb;
    logic             w_exc;
    logic             w_stall;
    logic             w_wb_valid;
    logic             r_is_div;
    logic             r_exc;
    logic             r_ctrl_mult;
    logic             r_ctrl_div;
    logic [4:0]       r_rd;
    logic [4:0]       r_wb_reg;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_wb_data;
    logic [CNT_W-1:0] r_cnt;

    assign w_req      = (is_mult | is_div) & ~flush;
    assign w_accept   = (r_state == StIdle) & w_req;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT));
    assign w_to_wb    = (r_state == StWait) & ~flush & (unit_ready | w_timeout);
    // A timeout with no ready is reported as an exception.
    assign w_exc      = unit_ready ? unit_exc : 1'b1;
    assign w_wb_valid = (r_state == StWb);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_stall = w_req;
                if (w_req) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                w_stall      = 1'b1;
                w_state_next = flush ? StDrain : StWait;
            end
            StWait: begin
                w_stall = 1'b1;
                if (flush) begin
                    // If the unit finishes in the flush cycle there is nothing left to drain.
                    w_state_next = (unit_ready | w_timeout) ? StIdle : StDrain;
                end else if (unit_ready | w_timeout) begin
                    w_state_next = StWb;
                end
            end
            StWb: begin
                w_stall      = 1'b1;
                w_state_next = StIdle;
            end
            StDrain: begin
                // A younger request waits here until the unit is free again.
                w_stall = w_req;
                if (unit_ready | w_timeout) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Operand latch, start pulse, wait counter and result capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_is_div    <= 1'b0;
            r_exc       <= 1'b0;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_rd        <= '0;
            r_wb_reg    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_wb_data   <= '0;
            r_cnt       <= '0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            if (w_accept) begin
                // Multiply wins when both decode flags are set.
                r_a         <= op_a;
                r_b         <= op_b;
                r_rd        <= rd;
                r_is_div    <= ~is_mult;
                r_ctrl_mult <= is_mult;
                r_ctrl_div  <= ~is_mult;
                r_exc       <= 1'b0;
                r_cnt       <= '0;
            end
            if (r_state == StStart) begin
                r_cnt <= CNT_W'(1);
            end else if ((r_state == StWait) || (r_state == StDrain)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_to_wb) begin
                r_exc     <= w_exc;
                r_wb_reg  <= w_exc ? RstatusReg : r_rd;
                r_wb_data <= w_exc ? (r_is_div ? 32'd5 : 32'd4) : unit_result;
            end
        end
    end

    assign ctrl_mult = r_ctrl_mult;
    assign ctrl_div  = r_ctrl_div;
    assign unit_a    = r_a;
    assign unit_b    = r_b;
    assign stall     = w_stall;
    assign wb_valid  = w_wb_valid;
    assign wb_reg    = w_wb_valid ? r_wb_reg : 5'd0;
    assign wb_data   = w_wb_valid ? r_wb_data : 32'd0;
    assign busy      = (r_state != StIdle);

`ifdef MULTDIV_PERF_EN
    logic [15:0] r_perf_ops;
    logic [15:0] r_perf_stall;

    // Saturating completed-op and stall-cycle counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_wb_valid && !r_exc && (r_perf_ops != 16'hFFFF)) begin
                r_perf_ops <= r_perf_ops + 16'd1;
            end
            if (w_stall && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`else
    assign perf_ops   = 16'd0;
    assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected start pulses and
// writeback beats into queues; a negedge monitor pops and compares them.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        is_mult;
    logic        is_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        flush;
    logic        unit_ready;
    logic [31:0] unit_result;
    logic        unit_exc;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;
    logic [15:0] perf_ops;
    logic [15:0] perf_stall;

    multdiv_ctrl #(
        .TIMEOUT (40),
        .CNT_W   (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .is_mult     (is_mult),
        .is_div      (is_div),
        .op_a        (op_a),
        .op_b        (op_b),
        .rd          (rd),
        .flush       (flush),
        .unit_ready  (unit_ready),
        .unit_result (unit_result),
        .unit_exc    (unit_exc),
        .ctrl_mult   (ctrl_mult),
        .ctrl_div    (ctrl_div),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .busy        (busy),
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic div;
    } start_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rg;
        logic [31:0] data;
    } wb_t;

    start_t st_q[$];
    wb_t    wb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        is_mult     = 1'b0;
        is_div      = 1'b0;
        flush       = 1'b0;
        unit_ready  = 1'b0;
        unit_exc    = 1'b0;
        unit_result = 32'd0;
        op_a        = 32'd0;
        op_b        = 32'd0;
        rd          = 5'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_ctrl"},  32'({ctrl_div, ctrl_mult}), 32'd0);
        chk({tag, "_wbv"},   32'(wb_valid), 32'd0);
        chk({tag, "_wbreg"}, 32'(wb_reg), 32'd0);
        chk({tag, "_wbdat"}, wb_data, 32'd0);
        chk({tag, "_ua"},    unit_a, 32'd0);
        chk({tag, "_ub"},    unit_b, 32'd0);
        chk({tag, "_pops"},  32'(perf_ops), 32'd0);
        chk({tag, "_pstl"},  32'(perf_stall), 32'd0);
    endtask

    // Monitor: every start pulse / writeback beat must match the head of its queue.
    always @(negedge clock) begin
        start_t s;
        wb_t    w;
        if (ctrl_mult || ctrl_div) begin
            if (st_q.size() == 0) begin
                chk("start_unexpected", 32'({ctrl_div, ctrl_mult}), 32'd0);
            end else begin
                s = st_q.pop_front();
                chk("start_cycle", 32'(cyc), 32'(s.cyc));
                chk("start_kind", 32'({ctrl_div, ctrl_mult}), s.div ? 32'd2 : 32'd1);
            end
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                w = wb_q.pop_front();
                chk("wb_cycle", 32'(cyc), 32'(w.cyc));
                chk("wb_reg", 32'(wb_reg), 32'(w.rg));
                chk("wb_data", wb_data, w.data);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        reset = 1'b0;
        clear_inputs();
        repeat (3) step();
        chk_all_zero("rst");
        reset = 1'b1;
        step();

        // Mul 7*6 -> r5 = 42, ready 3 cycles after the pulse.
        c0 = cyc;
        is_mult = 1'b1; op_a = 32'd7; op_b = 32'd6; rd = 5'd5;
        st_q.push_back(start_t'{c0 + 1, 1'b0});
        wb_q.push_back(wb_t'{c0 + 5, 5'd5, 32'd42});
        #1 chk("s1_stall_req", 32'(stall), 32'd1);
        step();
        clear_inputs();
        chk("s1_stall_start", 32'(stall), 32'd1);
        chk("s1_unit_a", unit_a, 32'd7);
        chk("s1_unit_b", unit_b, 32'd6);
        step(); chk("s1_stall_w1", 32'(stall), 32'd1);
        step(); chk("s1_stall_w2", 32'(stall), 32'd1);
        step(); chk("s1_stall_w3", 32'(stall), 32'd1);
        unit_ready = 1'b1; unit_result = 32'd42;
        step();
        clear_inputs();
        chk("s1_stall_wb", 32'(stall), 32'd1);
        chk("s1_busy_wb", 32'(busy), 32'd1);
        step();
        chk("s1_stall_idle", 32'(stall), 32'd0);
        chk("s1_busy_idle", 32'(busy), 32'd0);
`ifdef MULTDIV_PERF_EN
        chk("s1_perf_ops", 32'(perf_ops), 32'd1);
        chk("s1_perf_stall", 32'(perf_stall), 32'd6);
`else
        chk("s1_perf_ops", 32'(perf_ops), 32'd0);
        chk("s1_perf_stall", 32'(perf_stall), 32'd0);
`endif
        step();

        // Div 9/0 with exception -> r30 = 5, ready 2 cycles after the pulse.
        c0 = cyc;
        is_div = 1'b1; op_a = 32'd9; op_b = 32'd0; rd = 5'd8;
        st_q.push_back(start_t'{c0 + 1, 1'b1});
        wb_q.push_back(wb_t'{c0 + 4, 5'd30, 32'd5});
        step();
        clear_inputs();
        chk("s2_unit_a", unit_a, 32'd9);
        step();
        step();
        unit_ready = 1'b1; unit_exc = 1'b1; unit_result = 32'hDEAD_BEEF;
        step();
        clear_inputs();
        step();
        chk("s2_busy_idle", 32'(busy), 32'd0);
        step();

        // Mul with no response: timeout at counter 40 -> r30 = 4.
        c0 = cyc;
        is_mult = 1'b1; op_a = 32'd1; op_b = 32'd1; rd = 5'd9;
        st_q.push_back(start_t'{c0 + 1, 1'b0});
        wb_q.push_back(wb_t'{c0 + 42, 5'd30, 32'd4});
        step();
        clear_inputs();
        repeat (40) step();
        chk("s3_busy_last_wait", 32'(busy), 32'd1);
        step();
        chk("s3_wbv", 32'(wb_valid), 32'd1);
        step();
        chk("s3_busy_idle", 32'(busy), 32'd0);
        chk("s3_stall_idle", 32'(stall), 32'd0);
        step();

        // Flush in WAIT, late ready, new mul held during DRAIN.
        c0 = cyc;
        is_mult = 1'b1; op_a = 32'd2; op_b = 32'd3; rd = 5'd4;
        st_q.push_back(start_t'{c0 + 1, 1'b0});
        step();
        clear_inputs();
        step();
        step();
        flush = 1'b1;
        step();
        clear_inputs();
        chk("s4_stall_drain", 32'(stall), 32'd0);
        chk("s4_busy_drain", 32'(busy), 32'd1);
        step();
        is_mult = 1'b1; op_a = 32'd3; op_b = 32'd4; rd = 5'd7;
        st_q.push_back(start_t'{c0 + 10, 1'b0});
        wb_q.push_back(wb_t'{c0 + 13, 5'd7, 32'd12});
        #1 chk("s4_stall_held", 32'(stall), 32'd1);
        chk("s4_busy_held", 32'(busy), 32'd1);
        step();
        step();
        step();
        unit_ready = 1'b1; unit_result = 32'd6;
        #1 chk("s4_stall_ready", 32'(stall), 32'd1);
        step();
        unit_ready = 1'b0; unit_result = 32'd0;
        chk("s4_busy_idle", 32'(busy), 32'd0);
        chk("s4_stall_idle_req", 32'(stall), 32'd1);
        step();
        clear_inputs();
        chk("s4_unit_a", unit_a, 32'd3);
        step();
        step();
        unit_ready = 1'b1; unit_result = 32'd12;
        step();
        clear_inputs();
        step();
        chk("s4_busy_end", 32'(busy), 32'd0);
        step();

        // Both flags with flush: nothing starts. Both flags without flush: multiply.
        is_mult = 1'b1; is_div = 1'b1; flush = 1'b1;
        #1 chk("s5_stall_flush", 32'(stall), 32'd0);
        step();
        clear_inputs();
        chk("s5_busy_flush", 32'(busy), 32'd0);
        c0 = cyc;
        is_mult = 1'b1; is_div = 1'b1; op_a = 32'd5; op_b = 32'd6; rd = 5'd3;
        st_q.push_back(start_t'{c0 + 1, 1'b0});
        wb_q.push_back(wb_t'{c0 + 3, 5'd3, 32'd30});
        step();
        clear_inputs();
        step();
        unit_ready = 1'b1; unit_result = 32'd30;
        step();
        clear_inputs();
        step();
        chk("s5_busy_end", 32'(busy), 32'd0);
        step();

        // Reset while in WAIT: everything clears, a late ready is ignored.
        c0 = cyc;
        is_mult = 1'b1; op_a = 32'd11; op_b = 32'd12; rd = 5'd6;
        st_q.push_back(start_t'{c0 + 1, 1'b0});
        step();
        clear_inputs();
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_all_zero("s6");
        step();
        unit_ready = 1'b1; unit_result = 32'd77;
        step();
        clear_inputs();
        step();
        chk("s6_busy_late", 32'(busy), 32'd0);
        step();

        chk("end_start_q_empty", 32'(st_q.size()), 32'd0);
        chk("end_wb_q_empty", 32'(wb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
